// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for N requesters sharing one WIDTH-bit tristate bus.
// Each ownership change is separated by TURN_CYC Hi-Z cycles and may be capped at MAX_HOLD cycles.
module tri_bus_arbiter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned N        = 4,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IDW     = $clog2(N)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [N-1:0]       req_i,
  input  logic [N*WIDTH-1:0] data_in_i,
  inout  wire  [WIDTH-1:0]   bus_io,
  output logic [N-1:0]       gnt_o,
  output logic               busy_o,
  output logic [IDW-1:0]     owner_o
);

  localparam int unsigned TCW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [TCW-1:0] TurnLast = TCW'(TURN_CYC - 1);
  localparam logic [HCW-1:0] HoldLast = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [IDW-1:0] LastIdx  = IDW'(N - 1);

  typedef enum logic [1:0] {StIdle, StTurn, StOwn} state_e;

  state_e           state_q;
  logic [N-1:0]     gnt_q;
  logic             busy_q;
  logic [IDW-1:0]   owner_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [TCW-1:0]   turn_cnt_q;
  logic [HCW-1:0]   hold_cnt_q;

  logic [IDW-1:0]   next_ptr;
  logic [IDW:0]     idle_pick;
  logic [IDW:0]     rel_pick;
  logic [N-1:0]     owner_onehot;
  logic             release_own;

  // Returns {found, index} of the first requester at or after start, wrapping modulo N.
  function automatic logic [IDW:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] start);
    logic [IDW:0] res;
    int           j;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (r[j]) res = {1'b1, IDW'(j)};
    end
    return res;
  endfunction

  always_comb begin
    next_ptr     = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
    idle_pick    = pick(req_i, rr_ptr_q);
    rel_pick     = pick(req_i, next_ptr);
    owner_onehot = '0;
    owner_onehot[owner_q] = 1'b1;
    release_own  = !req_i[owner_q] || ((MAX_HOLD != 0) && (hold_cnt_q == HoldLast));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      turn_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req_i) begin
            owner_q    <= idle_pick[IDW-1:0];
            turn_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= StTurn;
          end
        end
        StTurn: begin
          // Abort leaves rr_ptr alone so the pending order is unaffected.
          if (!req_i[owner_q]) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (turn_cnt_q == TurnLast) begin
            gnt_q      <= owner_onehot;
            hold_cnt_q <= '0;
            state_q    <= StOwn;
          end else begin
            turn_cnt_q <= turn_cnt_q + 1'b1;
          end
        end
        StOwn: begin
          if (release_own) begin
            gnt_q    <= '0;
            rr_ptr_q <= next_ptr;
            if (rel_pick[IDW]) begin
              owner_q    <= rel_pick[IDW-1:0];
              turn_cnt_q <= '0;
              state_q    <= StTurn;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end else if (MAX_HOLD != 0) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Drive enable comes only from registered state; data itself passes straight through.
  assign bus_io  = (state_q == StOwn) ? data_in_i[int'(owner_q)*WIDTH +: WIDTH] : {WIDTH{1'bz}};
  assign gnt_o   = gnt_q;
  assign busy_o  = busy_q;
  assign owner_o = owner_q;

endmodule
